// File: rtl/rs_multi_cdb_if.sv
// rs_multi_cdb_if -- bundle of every signal between the reservation station and
// the rest of the core, except clock and reset.
//
// Groups:
//   rdy_in, flush                        global stall / misprediction flush
//   issue_*                              op offered by the issue stage (valid/ready)
//   cdb_valid, cdb_id, cdb_value         CDB_NUM packed result broadcast channels,
//                                        channel c in [c*W +: W]
//   alu_*                                op presented to the ALU (valid/ready)
//   count                                number of occupied entries
//
// Modports:
//   slave  -- the reservation station's view
//   master -- the surrounding core's (or a testbench's) view
interface rs_multi_cdb_if #(
    parameter int RS_SIZE  = 8,
    parameter int ROB_BITS = 4,
    parameter int CDB_NUM  = 2,
    parameter int DATA_W   = 32,
    parameter int OP_W     = 6
);
    localparam int CNT_W = $clog2(RS_SIZE + 1);

    logic                         rdy_in;
    logic                         flush;

    logic                         issue_valid;
    logic                         issue_ready;
    logic [OP_W-1:0]              issue_op;
    logic [ROB_BITS-1:0]          issue_dest;
    logic [DATA_W-1:0]            issue_imm;
    logic [DATA_W-1:0]            issue_vj;
    logic [DATA_W-1:0]            issue_vk;
    logic [ROB_BITS-1:0]          issue_qj;
    logic [ROB_BITS-1:0]          issue_qk;
    logic                         issue_rdj;
    logic                         issue_rdk;

    logic [CDB_NUM-1:0]           cdb_valid;
    logic [CDB_NUM*ROB_BITS-1:0]  cdb_id;
    logic [CDB_NUM*DATA_W-1:0]    cdb_value;

    logic                         alu_valid;
    logic                         alu_ready;
    logic [OP_W-1:0]              alu_op;
    logic [DATA_W-1:0]            alu_vj;
    logic [DATA_W-1:0]            alu_vk;
    logic [DATA_W-1:0]            alu_imm;
    logic [ROB_BITS-1:0]          alu_dest;

    logic [CNT_W-1:0]             count;

    modport slave (
        input  rdy_in, flush,
        input  issue_valid, issue_op, issue_dest, issue_imm,
        input  issue_vj, issue_vk, issue_qj, issue_qk, issue_rdj, issue_rdk,
        output issue_ready,
        input  cdb_valid, cdb_id, cdb_value,
        output alu_valid, alu_op, alu_vj, alu_vk, alu_imm, alu_dest,
        input  alu_ready,
        output count
    );

    modport master (
        output rdy_in, flush,
        output issue_valid, issue_op, issue_dest, issue_imm,
        output issue_vj, issue_vk, issue_qj, issue_qk, issue_rdj, issue_rdk,
        input  issue_ready,
        output cdb_valid, cdb_id, cdb_value,
        input  alu_valid, alu_op, alu_vj, alu_vk, alu_imm, alu_dest,
        output alu_ready,
        input  count
    );
endinterface

// File: rtl/rs_multi_cdb.sv
// rs_multi_cdb -- reservation station between the issue stage and one ALU.
//
// Holds up to RS_SIZE ops, snoops CDB_NUM result broadcast channels to fill in
// missing operands (including in the cycle an op is issued), and presents the
// oldest fully-ready op to the ALU.
//
// Ports:
//   clk_in  clock
//   rst_in  asynchronous active-high reset, drops every entry
//   bus     rs_multi_cdb_if.slave: stall/flush, issue handshake, CDB channels,
//           ALU handshake and occupancy count
//
// Age tracking: each valid entry carries a rank, 0 = oldest. The valid ranks are
// always exactly 0..count-1, so a new op takes rank count (count-1 if an op
// leaves in the same cycle) and a dispatch closes the gap by decrementing every
// rank above the departing one.
module rs_multi_cdb #(
    parameter int RS_SIZE  = 8,
    parameter int ROB_BITS = 4,
    parameter int CDB_NUM  = 2,
    parameter int DATA_W   = 32,
    parameter int OP_W     = 6
) (
    input  logic           clk_in,
    input  logic           rst_in,
    rs_multi_cdb_if.slave  bus
);
    localparam int CNT_W = $clog2(RS_SIZE + 1);
    localparam int IDX_W = $clog2(RS_SIZE);

    // Entry state
    logic [RS_SIZE-1:0]  valid_reg;
    logic [RS_SIZE-1:0]  rdj_reg;
    logic [RS_SIZE-1:0]  rdk_reg;
    logic [OP_W-1:0]     op_reg   [RS_SIZE];
    logic [ROB_BITS-1:0] dest_reg [RS_SIZE];
    logic [ROB_BITS-1:0] qj_reg   [RS_SIZE];
    logic [ROB_BITS-1:0] qk_reg   [RS_SIZE];
    logic [DATA_W-1:0]   imm_reg  [RS_SIZE];
    logic [DATA_W-1:0]   vj_reg   [RS_SIZE];
    logic [DATA_W-1:0]   vk_reg   [RS_SIZE];
    logic [IDX_W-1:0]    age_reg  [RS_SIZE];
    logic [CNT_W-1:0]    count_reg;

    // {hit, value} from the CDB for each stored operand and for the issuing op
    logic [DATA_W:0]     j_wake [RS_SIZE];
    logic [DATA_W:0]     k_wake [RS_SIZE];
    logic [DATA_W:0]     iss_j_wake;
    logic [DATA_W:0]     iss_k_wake;

    logic [RS_SIZE-1:0]  ready_vec;
    logic                sel_found;
    logic [IDX_W-1:0]    sel_idx;
    logic [IDX_W-1:0]    sel_age;
    logic [IDX_W-1:0]    free_idx;
    logic                do_issue;
    logic                do_disp;
    logic [CNT_W-1:0]    count_next;
    logic [IDX_W-1:0]    age_new;
    logic [DATA_W-1:0]   iss_vj;
    logic [DATA_W-1:0]   iss_vk;
    logic                iss_rdj;
    logic                iss_rdk;

    // Searching from the highest channel down lets the lowest matching
    // channel overwrite any higher one.
    function automatic logic [DATA_W:0] cdb_lookup(
        input logic [ROB_BITS-1:0]         tag,
        input logic [CDB_NUM-1:0]          vld,
        input logic [CDB_NUM*ROB_BITS-1:0] ids,
        input logic [CDB_NUM*DATA_W-1:0]   vals
    );
        logic [DATA_W:0] res;
        res = '0;
        for (int c = CDB_NUM - 1; c >= 0; c--) begin
            if (vld[c] && ids[c*ROB_BITS +: ROB_BITS] == tag) begin
                res = {1'b1, vals[c*DATA_W +: DATA_W]};
            end
        end
        return res;
    endfunction

    for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_wake
        assign j_wake[gi] = cdb_lookup(qj_reg[gi], bus.cdb_valid, bus.cdb_id, bus.cdb_value);
        assign k_wake[gi] = cdb_lookup(qk_reg[gi], bus.cdb_valid, bus.cdb_id, bus.cdb_value);
    end

    assign iss_j_wake = cdb_lookup(bus.issue_qj, bus.cdb_valid, bus.cdb_id, bus.cdb_value);
    assign iss_k_wake = cdb_lookup(bus.issue_qk, bus.cdb_valid, bus.cdb_id, bus.cdb_value);

    assign iss_rdj = bus.issue_rdj | iss_j_wake[DATA_W];
    assign iss_rdk = bus.issue_rdk | iss_k_wake[DATA_W];
    assign iss_vj  = bus.issue_rdj ? bus.issue_vj : iss_j_wake[DATA_W-1:0];
    assign iss_vk  = bus.issue_rdk ? bus.issue_vk : iss_k_wake[DATA_W-1:0];

    assign ready_vec = valid_reg & rdj_reg & rdk_reg;

    // Oldest ready entry = ready entry with the smallest rank
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (ready_vec[i] && (!sel_found || age_reg[i] < sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_age   = age_reg[i];
            end
        end
    end

    // Lowest-index free entry; only used when issue_ready guarantees one exists
    always_comb begin
        free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!valid_reg[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    assign bus.issue_ready = (count_reg < CNT_W'(RS_SIZE));
    assign bus.count       = count_reg;
    assign bus.alu_valid   = bus.rdy_in & sel_found;

    assign do_issue = bus.rdy_in & bus.issue_valid & bus.issue_ready & ~bus.flush;
    assign do_disp  = bus.alu_valid & bus.alu_ready & ~bus.flush;

    always_comb begin
        count_next = count_reg;
        if (do_issue && !do_disp) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!do_issue && do_disp) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    assign age_new = do_disp ? IDX_W'(count_reg - CNT_W'(1)) : IDX_W'(count_reg);

    always_comb begin
        bus.alu_op   = '0;
        bus.alu_vj   = '0;
        bus.alu_vk   = '0;
        bus.alu_imm  = '0;
        bus.alu_dest = '0;
        if (bus.alu_valid) begin
            bus.alu_op   = op_reg[sel_idx];
            bus.alu_vj   = vj_reg[sel_idx];
            bus.alu_vk   = vk_reg[sel_idx];
            bus.alu_imm  = imm_reg[sel_idx];
            bus.alu_dest = dest_reg[sel_idx];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count_reg <= '0;
            valid_reg <= '0;
            rdj_reg   <= '0;
            rdk_reg   <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                op_reg[i]   <= '0;
                dest_reg[i] <= '0;
                qj_reg[i]   <= '0;
                qk_reg[i]   <= '0;
                imm_reg[i]  <= '0;
                vj_reg[i]   <= '0;
                vk_reg[i]   <= '0;
                age_reg[i]  <= '0;
            end
        end else if (bus.rdy_in) begin
            if (bus.flush) begin
                valid_reg <= '0;
                count_reg <= '0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (valid_reg[i] && !rdj_reg[i] && j_wake[i][DATA_W]) begin
                        rdj_reg[i] <= 1'b1;
                        vj_reg[i]  <= j_wake[i][DATA_W-1:0];
                    end
                    if (valid_reg[i] && !rdk_reg[i] && k_wake[i][DATA_W]) begin
                        rdk_reg[i] <= 1'b1;
                        vk_reg[i]  <= k_wake[i][DATA_W-1:0];
                    end
                    if (do_disp && valid_reg[i] && age_reg[i] > sel_age) begin
                        age_reg[i] <= age_reg[i] - IDX_W'(1);
                    end
                end
                if (do_disp) begin
                    valid_reg[sel_idx] <= 1'b0;
                end
                // The free entry is never the one being dispatched, so these
                // writes cannot collide with the updates above.
                if (do_issue) begin
                    valid_reg[free_idx] <= 1'b1;
                    op_reg[free_idx]    <= bus.issue_op;
                    dest_reg[free_idx]  <= bus.issue_dest;
                    imm_reg[free_idx]   <= bus.issue_imm;
                    qj_reg[free_idx]    <= bus.issue_qj;
                    qk_reg[free_idx]    <= bus.issue_qk;
                    vj_reg[free_idx]    <= iss_vj;
                    vk_reg[free_idx]    <= iss_vk;
                    rdj_reg[free_idx]   <= iss_rdj;
                    rdk_reg[free_idx]   <= iss_rdk;
                    age_reg[free_idx]   <= age_new;
                end
                count_reg <= count_next;
            end
        end
    end
endmodule

// File: tb/tb_rs_multi_cdb.sv
// tb_rs_multi_cdb -- directed bench for rs_multi_cdb (RS_SIZE=8, 2 CDB channels).
// Walks through in-order dispatch, CDB wakeup (stored and same-cycle, channel
// priority), full/back-pressure, stall, flush and asynchronous reset.
module tb_rs_multi_cdb;
    localparam int RS_SIZE  = 8;
    localparam int ROB_BITS = 4;
    localparam int CDB_NUM  = 2;
    localparam int DATA_W   = 32;
    localparam int OP_W     = 6;

    logic clk_in;
    logic rst_in;
    int   checks;
    int   failures;

    rs_multi_cdb_if #(
        .RS_SIZE(RS_SIZE), .ROB_BITS(ROB_BITS), .CDB_NUM(CDB_NUM),
        .DATA_W(DATA_W), .OP_W(OP_W)
    ) bus ();

    rs_multi_cdb #(
        .RS_SIZE(RS_SIZE), .ROB_BITS(ROB_BITS), .CDB_NUM(CDB_NUM),
        .DATA_W(DATA_W), .OP_W(OP_W)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge; outputs are read 2 later.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive_issue(input logic [5:0] op, input logic [3:0] dest,
                               input logic [31:0] imm, input logic [31:0] vj,
                               input logic [31:0] vk, input logic [3:0] qj,
                               input logic [3:0] qk, input logic rdj, input logic rdk);
        bus.issue_valid = 1'b1;
        bus.issue_op    = op;
        bus.issue_dest  = dest;
        bus.issue_imm   = imm;
        bus.issue_vj    = vj;
        bus.issue_vk    = vk;
        bus.issue_qj    = qj;
        bus.issue_qk    = qk;
        bus.issue_rdj   = rdj;
        bus.issue_rdk   = rdk;
        $display("issue op=%0d dest=%0d vj=0x%0h vk=0x%0h rdj=%0d qj=%0d rdk=%0d qk=%0d",
                 op, dest, vj, vk, rdj, qj, rdk, qk);
    endtask

    task automatic drive_cdb(input int c, input logic [3:0] id, input logic [31:0] val);
        bus.cdb_valid[c]             = 1'b1;
        bus.cdb_id[c*ROB_BITS +: 4]  = id;
        bus.cdb_value[c*DATA_W +: 32] = val;
        $display("cdb ch=%0d id=%0d value=0x%0h", c, id, val);
    endtask

    task automatic clear_cdb();
        bus.cdb_valid = '0;
        bus.cdb_id    = '0;
        bus.cdb_value = '0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_in          = 1'b1;
        bus.rdy_in      = 1'b1;
        bus.flush       = 1'b0;
        bus.issue_valid = 1'b0;
        bus.issue_op    = '0;
        bus.issue_dest  = '0;
        bus.issue_imm   = '0;
        bus.issue_vj    = '0;
        bus.issue_vk    = '0;
        bus.issue_qj    = '0;
        bus.issue_qk    = '0;
        bus.issue_rdj   = 1'b0;
        bus.issue_rdk   = 1'b0;
        bus.alu_ready   = 1'b0;
        clear_cdb();

        // ---- reset state
        #12;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_issue_ready", 32'(bus.issue_ready), 1);
        chk("rst_alu_valid", 32'(bus.alu_valid), 0);
        chk("rst_alu_vj", bus.alu_vj, 0);
        rst_in = 1'b0;
        tick();

        // ---- three ready ops dispatched in issue order
        bus.alu_ready = 1'b1;
        drive_issue(6'd1, 4'd1, 32'h0, 32'd5, 32'd50, 4'd0, 4'd0, 1'b1, 1'b1);
        settle();
        chk("t1_issue_cycle_alu_valid", 32'(bus.alu_valid), 0);
        tick();
        drive_issue(6'd1, 4'd2, 32'h0, 32'd6, 32'd60, 4'd0, 4'd0, 1'b1, 1'b1);
        settle();
        chk("t1_first_vj", bus.alu_vj, 5);
        chk("t1_first_dest", 32'(bus.alu_dest), 1);
        chk("t1_count_a", 32'(bus.count), 1);
        tick();
        drive_issue(6'd1, 4'd3, 32'h0, 32'd7, 32'd70, 4'd0, 4'd0, 1'b1, 1'b1);
        settle();
        chk("t1_second_vj", bus.alu_vj, 6);
        chk("t1_second_vk", bus.alu_vk, 60);
        tick();
        bus.issue_valid = 1'b0;
        settle();
        chk("t1_third_vj", bus.alu_vj, 7);
        chk("t1_count_b", 32'(bus.count), 1);
        tick();
        settle();
        chk("t1_count_empty", 32'(bus.count), 0);
        chk("t1_alu_valid_empty", 32'(bus.alu_valid), 0);
        chk("t1_alu_vj_zero", bus.alu_vj, 0);

        // ---- stored-entry wakeup; the younger ready op goes first
        drive_issue(6'd2, 4'd2, 32'h0, 32'h0, 32'h2, 4'd3, 4'd0, 1'b0, 1'b1);
        settle();
        tick();
        drive_issue(6'd3, 4'd3, 32'h0, 32'hB, 32'h0, 4'd0, 4'd0, 1'b1, 1'b1);
        settle();
        chk("t2_a_waiting", 32'(bus.alu_valid), 0);
        tick();
        bus.issue_valid = 1'b0;
        drive_cdb(1, 4'd3, 32'hDEAD);
        settle();
        chk("t2_b_dest", 32'(bus.alu_dest), 3);
        chk("t2_b_vj", bus.alu_vj, 32'hB);
        tick();
        clear_cdb();
        settle();
        chk("t2_a_dest", 32'(bus.alu_dest), 2);
        chk("t2_a_vj", bus.alu_vj, 32'hDEAD);
        chk("t2_a_op", 32'(bus.alu_op), 2);
        tick();
        settle();
        chk("t2_count_empty", 32'(bus.count), 0);

        // ---- same-cycle wakeup at issue, both channels match: channel 0 wins
        drive_issue(6'd5, 4'd7, 32'h100, 32'h0, 32'h3, 4'd4, 4'd0, 1'b0, 1'b1);
        drive_cdb(0, 4'd4, 32'h11);
        drive_cdb(1, 4'd4, 32'h99);
        settle();
        chk("t3_issue_cycle_alu_valid", 32'(bus.alu_valid), 0);
        tick();
        bus.issue_valid = 1'b0;
        clear_cdb();
        settle();
        chk("t3_alu_valid", 32'(bus.alu_valid), 1);
        chk("t3_alu_vj", bus.alu_vj, 32'h11);
        chk("t3_alu_imm", bus.alu_imm, 32'h100);
        chk("t3_alu_op", 32'(bus.alu_op), 5);
        tick();

        // ---- stored k operand, both channels match: channel 0 wins
        drive_issue(6'd6, 4'd8, 32'h0, 32'h1, 32'h0, 4'd0, 4'd6, 1'b1, 1'b0);
        settle();
        tick();
        bus.issue_valid = 1'b0;
        drive_cdb(0, 4'd6, 32'hAA);
        drive_cdb(1, 4'd6, 32'hBB);
        settle();
        chk("t3k_waiting", 32'(bus.alu_valid), 0);
        tick();
        clear_cdb();
        settle();
        chk("t3k_alu_vk", bus.alu_vk, 32'hAA);
        chk("t3k_alu_dest", 32'(bus.alu_dest), 8);
        tick();
        settle();
        chk("t3k_count_empty", 32'(bus.count), 0);

        // ---- fill all entries with the ALU stalled; last one waits on tag 9
        bus.alu_ready = 1'b0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (i == RS_SIZE - 1)
                drive_issue(6'd4, 4'(i), 32'h0, 32'h10 + 32'(i), 32'h0, 4'd9, 4'd0, 1'b0, 1'b1);
            else
                drive_issue(6'd4, 4'(i), 32'h0, 32'h10 + 32'(i), 32'h0, 4'd0, 4'd0, 1'b1, 1'b1);
            settle();
            chk("t4_fill_issue_ready", 32'(bus.issue_ready), 1);
            tick();
        end
        drive_issue(6'd4, 4'hF, 32'h0, 32'h99, 32'h0, 4'd0, 4'd0, 1'b1, 1'b1);
        settle();
        chk("t4_full_count", 32'(bus.count), 8);
        chk("t4_full_issue_ready", 32'(bus.issue_ready), 0);
        chk("t4_full_oldest_vj", bus.alu_vj, 32'h10);
        tick();
        settle();
        chk("t4_ninth_ignored", 32'(bus.count), 8);
        bus.alu_ready = 1'b1;
        #1;
        chk("t4_no_same_cycle_ready", 32'(bus.issue_ready), 0);
        tick();
        bus.alu_ready   = 1'b0;
        bus.issue_valid = 1'b0;
        settle();
        chk("t4_count_after_disp", 32'(bus.count), 7);
        chk("t4_issue_ready_after", 32'(bus.issue_ready), 1);
        chk("t4_next_oldest_vj", bus.alu_vj, 32'h11);

        // drain two more, leaving 13,14,15,16 and the waiting entry
        bus.alu_ready = 1'b1;
        settle();
        chk("t4_drain_a", bus.alu_vj, 32'h11);
        tick();
        settle();
        chk("t4_drain_b", bus.alu_vj, 32'h12);
        tick();
        bus.alu_ready = 1'b0;
        settle();
        chk("t4_count_five", 32'(bus.count), 5);

        // ---- stall: issue, CDB and ALU activity all ignored
        bus.rdy_in    = 1'b0;
        bus.alu_ready = 1'b1;
        drive_issue(6'd7, 4'd9, 32'h0, 32'h55, 32'h0, 4'd0, 4'd0, 1'b1, 1'b1);
        drive_cdb(0, 4'd9, 32'h77);
        for (int s = 0; s < 3; s++) begin
            settle();
            chk("t6_stall_alu_valid", 32'(bus.alu_valid), 0);
            chk("t6_stall_count", 32'(bus.count), 5);
            tick();
        end
        bus.rdy_in      = 1'b1;
        bus.issue_valid = 1'b0;
        bus.alu_ready   = 1'b0;
        clear_cdb();
        settle();
        chk("t6_resume_count", 32'(bus.count), 5);
        chk("t6_resume_vj", bus.alu_vj, 32'h13);
        bus.alu_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("t6_order_vj", bus.alu_vj, 32'h13 + 32'(k));
            tick();
        end
        settle();
        chk("t6_waiter_not_woken", 32'(bus.alu_valid), 0);
        chk("t6_count_one", 32'(bus.count), 1);
        drive_cdb(0, 4'd9, 32'h77);
        tick();
        clear_cdb();
        settle();
        chk("t6_waiter_vj", bus.alu_vj, 32'h77);
        chk("t6_waiter_dest", 32'(bus.alu_dest), 7);
        tick();
        settle();
        chk("t6_count_empty", 32'(bus.count), 0);

        // ---- flush beats issue and dispatch
        bus.alu_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_issue(6'd8, 4'(i), 32'h0, 32'h20 + 32'(i), 32'h0, 4'd0, 4'd0, 1'b1, 1'b1);
            tick();
        end
        drive_issue(6'd8, 4'd5, 32'h0, 32'h25, 32'h0, 4'd0, 4'd0, 1'b1, 1'b1);
        bus.flush     = 1'b1;
        bus.alu_ready = 1'b1;
        $display("flush with issue and alu_ready");
        settle();
        chk("t5_pre_flush_count", 32'(bus.count), 5);
        tick();
        bus.flush       = 1'b0;
        bus.issue_valid = 1'b0;
        settle();
        chk("t5_flush_count", 32'(bus.count), 0);
        chk("t5_flush_alu_valid", 32'(bus.alu_valid), 0);
        chk("t5_flush_issue_ready", 32'(bus.issue_ready), 1);
        tick();
        settle();
        chk("t5_issue_lost", 32'(bus.count), 0);

        // ---- asynchronous reset mid-operation
        bus.alu_ready = 1'b0;
        drive_issue(6'd9, 4'd1, 32'h0, 32'h30, 32'h0, 4'd0, 4'd0, 1'b1, 1'b1);
        tick();
        drive_issue(6'd9, 4'd2, 32'h0, 32'h31, 32'h0, 4'd0, 4'd0, 1'b1, 1'b1);
        tick();
        bus.issue_valid = 1'b0;
        settle();
        chk("t7_pre_reset_count", 32'(bus.count), 2);
        #1;
        rst_in = 1'b1;
        $display("async reset asserted between edges");
        #1;
        chk("t7_async_count", 32'(bus.count), 0);
        chk("t7_async_alu_valid", 32'(bus.alu_valid), 0);
        rst_in = 1'b0;
        tick();
        settle();
        chk("t7_after_reset_count", 32'(bus.count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
